// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU iterative divide path: FSM state type,
// exponent bias, iteration count and the canonical special-value encodings.
// No ports.
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    localparam logic [9:0]  FP_BIAS  = 10'd127;
    localparam int unsigned DIV_ITER = 27;
    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF   = 32'h7F80_0000;

    // Counter load value: one quotient bit per cycle, counting down to zero.
    localparam logic [4:0]  DIV_CNT_LOAD = 5'(DIV_ITER - 1);

endpackage

// File: rtl/fpu_round_pack.sv
// -----------------------------------------------------------------------------
// fpu_round_pack
// Combinational normalise / round / pack stage for a 27-bit quotient-style
// significand (integer bit at quo[26]). Usable by any FPU path that produces
// a significand in [0.5, 2) with three extra low bits plus a sticky source.
//
// Ports
//   sign     in   1   result sign
//   exp      in  10   biased exponent, two's complement, before normalisation
//   quo      in  27   significand bits, quo[26] has weight 1
//   sticky   in   1   OR of all bits below quo[0]
//   result   out 32   packed {sign, exp[7:0], mantissa}
//   overflow out  1   final exponent outside 0..255
// -----------------------------------------------------------------------------
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic        sign,
    input  logic [9:0]  exp,
    input  logic [26:0] quo,
    input  logic        sticky,
    output logic [31:0] result,
    output logic        overflow
);

    logic [22:0] mant_s;
    logic [9:0]  exp_s;
    logic        guard_s;
    logic        round_s;
    logic        sticky_s;
    logic        round_up_s;

    // Normalise by one position when the integer bit is clear, then round and pack.
    always_comb begin
        mant_s     = 23'd0;
        exp_s      = exp;
        guard_s    = 1'b0;
        round_s    = 1'b0;
        sticky_s   = 1'b0;
        round_up_s = 1'b0;

        if (quo[26]) begin
            mant_s   = quo[25:3];
            guard_s  = quo[2];
            round_s  = quo[1];
            sticky_s = quo[0] | sticky;
            exp_s    = exp;
        end else begin
            mant_s   = quo[24:2];
            guard_s  = quo[1];
            round_s  = quo[0];
            sticky_s = sticky;
            exp_s    = exp - 10'd1;
        end

        // Shared FPU rounding rule: exact ties are not rounded up.
        round_up_s = guard_s & (round_s | sticky_s);

        if (round_up_s) begin
            if (&mant_s) begin
                // 1.111..1 + ulp = 10.0: renormalise into the exponent.
                mant_s = 23'd0;
                exp_s  = exp_s + 10'd1;
            end else begin
                mant_s = mant_s + 23'd1;
            end
        end else begin
            mant_s = mant_s;
        end

        result   = {sign, exp_s[7:0], mant_s};
        overflow = |exp_s[9:8];
    end

endmodule

// File: rtl/fpu_div_iter.sv
// -----------------------------------------------------------------------------
// fpu_div_iter
// Iterative single-precision divider (FDIV.S): operand1 / operand2 using a
// radix-2 restoring iteration (27 quotient bits), followed by normalise,
// round and pack in fpu_round_pack. Latency accept -> valid_o is 29 cycles.
//
// Optional feature macro: FPU_DIV_SPECIAL_EN
//   defined   - zero / inf / NaN operands are classified at accept and take a
//               fast path straight to ROUND; fpu_div_dz_o reports divide-by-zero.
//   undefined - every operand is treated as normalised; fpu_div_dz_o is 0.
//
// Ports
//   clk_i             in   1   clock
//   rst_i             in   1   synchronous active-high reset
//   flush_i           in   1   abort in-flight operation, clear outputs
//   valid_i           in   1   operands valid
//   ready_o           out  1   idle, able to accept
//   operand1_i        in  32   dividend
//   operand2_i        in  32   divisor
//   valid_o           out  1   result valid
//   ready_i           in   1   consumer accepts the result
//   fpu_div_result_o  out 32   packed quotient
//   fpu_div_overflow  out  1   final biased exponent outside 0..255
//   fpu_div_dz_o      out  1   divide-by-zero
// -----------------------------------------------------------------------------
module fpu_div_iter
    import fpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] operand1_i,
    input  logic [31:0] operand2_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] fpu_div_result_o,
    output logic        fpu_div_overflow,
    output logic        fpu_div_dz_o
);

    div_state_t  state_r;
    div_state_t  state_next_s;

    logic        sign_r;
    logic [9:0]  exp_r;
    logic [24:0] rem_r;
    logic [24:0] div_r;
    logic [26:0] quo_r;
    logic [4:0]  cnt_r;

    logic        accept_s;
    logic        special_s;
    logic [24:0] rem_diff_s;
    logic [24:0] rem_step_s;
    logic        q_bit_s;

    logic [31:0] pack_res_s;
    logic        pack_ov_s;

    logic [31:0] result_r;
    logic        overflow_r;
    logic        dz_r;
    logic        valid_r;
    logic        ready_r;

`ifdef FPU_DIV_SPECIAL_EN
    logic        special_r;
    logic [31:0] special_res_r;
    logic        special_dz_r;
    logic [31:0] special_res_s;
    logic        special_dz_s;
    logic        sign_in_s;

    // Classify operands on the input side; zero means a zero exponent field.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = 32'd0;
        special_dz_s  = 1'b0;
        sign_in_s     = operand1_i[31] ^ operand2_i[31];

        if ((operand1_i[30:23] == 8'hFF) || (operand2_i[30:23] == 8'hFF) ||
            ((operand1_i[30:23] == 8'h00) && (operand2_i[30:23] == 8'h00))) begin
            special_s     = 1'b1;
            special_res_s = FP_QNAN;
        end else if (operand2_i[30:23] == 8'h00) begin
            special_s     = 1'b1;
            special_res_s = FP_INF | {sign_in_s, 31'd0};
            special_dz_s  = 1'b1;
        end else if (operand1_i[30:23] == 8'h00) begin
            special_s     = 1'b1;
            special_res_s = {sign_in_s, 31'd0};
        end else begin
            special_s     = 1'b0;
        end
    end
`else
    assign special_s = 1'b0;
`endif

    // Flush outranks accept, so an accept is never taken in a flush cycle.
    assign accept_s = valid_i & ready_r & ~flush_i;

    // One restoring step: trial subtract, keep the difference when it fits.
    always_comb begin
        rem_diff_s = rem_r - div_r;
        if (rem_r >= div_r) begin
            q_bit_s    = 1'b1;
            rem_step_s = rem_diff_s << 1;
        end else begin
            q_bit_s    = 1'b0;
            rem_step_s = rem_r << 1;
        end
    end

    // Next-state logic of the divide sequencer.
    always_comb begin
        state_next_s = state_r;
        if (flush_i) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_next_s = special_s ? ROUND : DIVIDE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DIVIDE: begin
                    if (cnt_r == 5'd0) begin
                        state_next_s = ROUND;
                    end else begin
                        state_next_s = DIVIDE;
                    end
                end
                ROUND: begin
                    state_next_s = DONE;
                end
                DONE: begin
                    if (valid_r && ready_i) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture at accept and quotient iteration while dividing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_r <= 1'b0;
            exp_r  <= 10'd0;
            rem_r  <= 25'd0;
            div_r  <= 25'd0;
            quo_r  <= 27'd0;
            cnt_r  <= 5'd0;
        end else if (accept_s) begin
            sign_r <= operand1_i[31] ^ operand2_i[31];
            exp_r  <= {2'b00, operand1_i[30:23]} - {2'b00, operand2_i[30:23]} + FP_BIAS;
            rem_r  <= {2'b01, operand1_i[22:0]};
            div_r  <= {2'b01, operand2_i[22:0]};
            quo_r  <= 27'd0;
            cnt_r  <= DIV_CNT_LOAD;
        end else if (state_r == DIVIDE) begin
            rem_r  <= rem_step_s;
            quo_r  <= {quo_r[25:0], q_bit_s};
            cnt_r  <= (cnt_r == 5'd0) ? 5'd0 : (cnt_r - 5'd1);
        end else begin
            cnt_r  <= cnt_r;
        end
    end

`ifdef FPU_DIV_SPECIAL_EN
    // Remember the special-case verdict for the ROUND cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            special_r     <= 1'b0;
            special_res_r <= 32'd0;
            special_dz_r  <= 1'b0;
        end else if (accept_s) begin
            special_r     <= special_s;
            special_res_r <= special_res_s;
            special_dz_r  <= special_dz_s;
        end else begin
            special_r     <= special_r;
        end
    end
`endif

    fpu_round_pack u_round_pack (
        .sign     (sign_r),
        .exp      (exp_r),
        .quo      (quo_r),
        .sticky   (|rem_r),
        .result   (pack_res_s),
        .overflow (pack_ov_s)
    );

    // Registered handshake outputs and result capture on ROUND -> DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
            dz_r       <= 1'b0;
            valid_r    <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            valid_r <= (state_next_s == DONE);
            ready_r <= (state_next_s == IDLE);
            if (state_r == ROUND) begin
`ifdef FPU_DIV_SPECIAL_EN
                if (special_r) begin
                    result_r   <= special_res_r;
                    overflow_r <= 1'b0;
                    dz_r       <= special_dz_r;
                end else begin
                    result_r   <= pack_res_s;
                    overflow_r <= pack_ov_s;
                    dz_r       <= 1'b0;
                end
`else
                result_r   <= pack_res_s;
                overflow_r <= pack_ov_s;
                dz_r       <= 1'b0;
`endif
            end else begin
                result_r   <= result_r;
            end
        end
    end

    assign ready_o          = ready_r;
    assign valid_o          = valid_r;
    assign fpu_div_result_o = result_r;
    assign fpu_div_overflow = overflow_r;
    assign fpu_div_dz_o     = dz_r;

endmodule

// File: tb/tb_fpu_div_iter.sv
// -----------------------------------------------------------------------------
// tb_fpu_div_iter
// Self-checking bench for fpu_div_iter: directed vectors, handshake stall,
// flush, and random operands checked against an exact-arithmetic reference.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpu_div_iter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand1_i;
    logic [31:0] operand2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] fpu_div_result_o;
    logic        fpu_div_overflow;
    logic        fpu_div_dz_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpu_div_iter dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .operand1_i       (operand1_i),
        .operand2_i       (operand2_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .fpu_div_result_o (fpu_div_result_o),
        .fpu_div_overflow (fpu_div_overflow),
        .fpu_div_dz_o     (fpu_div_dz_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Exact quotient: significand ratio scaled to 24 bits, round up only when
    // the discarded fraction is strictly greater than one half.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ov);
        longint      m1, m2, num, mant, rem;
        int          e;
        logic [31:0] e_bits;
        m1 = longint'({1'b1, a[22:0]});
        m2 = longint'({1'b1, b[22:0]});
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (m1 >= m2) begin
            num = m1 << 23;
        end else begin
            num = m1 << 24;
            e   = e - 1;
        end
        mant = num / m2;
        rem  = num - mant * m2;
        if (2 * rem > m2) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e    = e + 1;
        end
        ov     = (e < 0) || (e > 255);
        e_bits = e;
        res    = {a[31] ^ b[31], e_bits[7:0], mant[22:0]};
    endfunction

    // Present operands, then wait (bounded) for valid_o; lat counts cycles after accept.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        chk("ready_before_accept", {31'd0, ready_o}, 32'd1);
        operand1_i = a;
        operand2_i = b;
        valid_i    = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat     = 1;
        while (valid_o !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic end_op(input string tag);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, ready_o}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ov,
                          input logic exp_dz, input int exp_lat);
        int lat;
        start_op(a, b, lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, fpu_div_result_o, exp_res);
        chk({tag, "_overflow"}, {31'd0, fpu_div_overflow}, {31'd0, exp_ov});
        chk({tag, "_dz"}, {31'd0, fpu_div_dz_o}, {31'd0, exp_dz});
        end_op(tag);
    endtask

    task automatic idle_watch(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) seen++;
        end
        chk(tag, seen, 0);
    endtask

    function automatic logic [31:0] rand_fp(input bit narrow);
        logic [7:0] e;
        if (narrow) e = 8'($urandom_range(134, 120));
        else        e = 8'($urandom_range(254, 1));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, rres, held;
        logic        rov;
        int          lat;

        rst_i      = 1'b1;
        flush_i    = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        operand1_i = 32'd0;
        operand2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_result", fpu_div_result_o, 32'd0);
        chk("reset_overflow", {31'd0, fpu_div_overflow}, 32'd0);
        chk("reset_dz", {31'd0, fpu_div_dz_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 29);
        run_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 29);
        run_op("one_div_half", 32'h3F80_0000, 32'h3F00_0000, 32'h4000_0000, 1'b0, 1'b0, 29);
        run_op("exp_overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h0000_0000, 1'b1, 1'b0, 29);
        run_op("neg_div", 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 1'b0, 29);

        // Consumer stall in DONE, with an ignored valid_i pulse
        ready_i = 1'b0;
        start_op(32'h40C0_0000, 32'h4000_0000, lat);
        chk("stall_latency", lat, 29);
        held = fpu_div_result_o;
        chk("stall_first_result", held, 32'h4040_0000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                operand1_i = 32'h3F80_0000;
                operand2_i = 32'h4040_0000;
                valid_i    = 1'b1;
            end else begin
                valid_i    = 1'b0;
            end
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
            chk("stall_result", fpu_div_result_o, 32'h4040_0000);
            chk("stall_ready", {31'd0, ready_o}, 32'd0);
            chk("stall_overflow", {31'd0, fpu_div_overflow}, 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        end_op("stall_release");
        idle_watch(35, "stall_no_extra_valid");

        // Flush ten cycles after accept
        operand1_i = 32'h3F80_0000;
        operand2_i = 32'h4040_0000;
        valid_i    = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_ready", {31'd0, ready_o}, 32'd1);
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        chk("flush_result_cleared", fpu_div_result_o, 32'd0);
        idle_watch(40, "flush_no_valid");
        run_op("after_flush", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 29);

        // Flush wins over a same-cycle accept
        operand1_i = 32'h40C0_0000;
        operand2_i = 32'h4000_0000;
        valid_i    = 1'b1;
        flush_i    = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_accept_ready", {31'd0, ready_o}, 32'd1);
        idle_watch(35, "flush_accept_no_valid");

`ifdef FPU_DIV_SPECIAL_EN
        run_op("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 2);
        run_op("nan_in", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2);
        run_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2);
        run_op("zero_dividend", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
`endif

        // Random operands against the reference
        for (int i = 0; i < 30; i++) begin
            a = rand_fp(i[0]);
            b = rand_fp(i[0]);
            if (i % 5 == 0) b[22:0] = a[22:0];
            ref_div(a, b, rres, rov);
            run_op("random", a, b, rres, rov, 1'b0, 29);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_div_iter.md
# fpu_div_iter

Iterative single-precision floating-point divider, the inverse companion to the FPU's combined multiply/add-sub datapath. It accepts operand1 ÷ operand2 over a valid/ready handshake, generates the quotient with a radix-2 restoring iteration, then normalises and rounds. It returns the packed result with the same overflow flag and rounding behaviour as the multiply and add paths. It sits beside the mul/alu unit in the FPU and serves FDIV.S.

## Interface
- No parameters; the iteration count is fixed by package constant DIV_ITER = 27.
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- flush_i  input  1  abort the in-flight operation.
- valid_i  input  1  operands valid.
- ready_o  output  1  unit idle and able to accept.
- operand1_i  input  32  dividend, IEEE-754 single.
- operand2_i  input  32  divisor, IEEE-754 single.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- fpu_div_result_o  output  32  packed quotient.
- fpu_div_overflow  output  1  final biased exponent is outside 0..255.
- fpu_div_dz_o  output  1  divide-by-zero; constant 0 unless FPU_DIV_SPECIAL_EN is defined.

## Operation
- FSM states: IDLE, DIVIDE, ROUND, DONE.
- Reset values: state IDLE, ready_o 1, valid_o 0, fpu_div_result_o 0, fpu_div_overflow 0, fpu_div_dz_o 0.
- ready_o is 1 only in IDLE.
- Accept occurs when valid_i & ready_o. On accept the unit latches:
  - sign = s1 ^ s2;
  - exponent = e1 − e2 + 127, as a 10-bit signed value;
  - rem = {1, m1} and div = {1, m2}, each 24 bits plus a guard bit;
  - iteration counter = 26.
- DIVIDE, one quotient bit per cycle:
  - if rem ≥ div, then rem −= div and shift in q = 1; otherwise shift in q = 0;
  - then rem <<= 1;
  - after the counter reaches 0, move to ROUND.
- The quotient q is 27 bits.
  - If q[26] = 1: mantissa = q[25:3], guard = q[2], round = q[1], sticky = q[0] | (rem ≠ 0).
  - Otherwise: mantissa = q[24:2], guard = q[1], round = q[0], sticky = (rem ≠ 0), and exponent −= 1.
- Rounding in ROUND:
  - round_up = guard & (round | sticky). This is the FPU-wide rounding rule, not RNE-ties-even.
  - If the mantissa is all ones and round_up is set, the mantissa wraps to 0 and exponent += 1.
- Packing: result = {sign, exp[7:0], mant}; fpu_div_overflow = (exp[9:8] ≠ 0). Both are registered on the transition into DONE.
- DONE:
  - valid_o = 1; the result and flags are held stable until ready_i;
  - on valid_o & ready_i, go to IDLE, and valid_o drops the next cycle.
- valid_i outside IDLE is ignored; no queueing.
- flush_i:
  - in any state, go to IDLE next cycle, with valid_o 0 and outputs cleared;
  - it has priority over a same-cycle accept or result handshake;
  - no partial result is ever presented.
- rst_i mid-operation behaves the same as flush_i and also clears all datapath registers.

## Timing
- Accept in cycle T.
- DIVIDE occupies T+1..T+27.
- ROUND occupies T+28.
- valid_o rises at T+29 (latency 29).
- The earliest next accept is the cycle after the result handshake. Back-to-back throughput is 1 operation per 30 cycles when ready_i is held high.
- Special-case fast path (macro defined only): IDLE → ROUND, so valid_o rises at T+2.

## Configuration
- FPU_DIV_SPECIAL_EN defined, classification at accept:
  - exponent 255 on either operand, or 0/0: result 0x7FC00000;
  - divisor exponent 0, dividend non-zero: result sign | 0x7F800000, fpu_div_dz_o = 1;
  - dividend exponent 0: result sign | 0x00000000;
  - all special cases take the fast path and force fpu_div_overflow = 0.
- FPU_DIV_SPECIAL_EN undefined:
  - every operand is treated as normalised with an implicit 1, matching mul/alu;
  - fpu_div_dz_o is tied to 0 and there is no fast path.

## Structure
- fpu_pkg holds:
  - the div_state_t enum;
  - FP_BIAS = 127;
  - DIV_ITER = 27;
  - FP_QNAN = 32'h7FC00000 and FP_INF = 32'h7F800000.
- One sub-module, fpu_round_pack (combinational): takes sign, 10-bit exponent, 27-bit quotient and the sticky input. It returns the packed word and the overflow flag, and is reusable by other FPU paths.

## Test plan
- 0x40C00000 ÷ 0x40000000 (6/2) → 0x40400000, overflow 0, valid_o exactly at accept+29.
- 0x3F800000 ÷ 0x40400000 (1/3) → 0x3EAAAAAB: guard = 1 and sticky = 1 round up. Also 0x3F800000 ÷ 0x3F000000 → 0x40000000.
- 0x7F000000 ÷ 0x3E800000 → exponent 256, fpu_div_overflow = 1, fpu_div_result_o = 0x00000000.
- ready_i held low for 5 cycles in DONE:
  - valid_o, the result and the flags stay stable;
  - ready_o stays 0 and a valid_i pulse is ignored;
  - release ready_i → IDLE next cycle.
- flush_i at accept+10:
  - ready_o = 1 next cycle and no valid_o ever appears for that operation;
  - a following 6/2 operation returns 0x40400000.
- Macro defined: 0x3F800000 ÷ 0x00000000 → 0x7F800000 with fpu_div_dz_o = 1 at accept+2; 0x7FC00000 ÷ 0x3F800000 → 0x7FC00000.
